unum4_unpack: RTL

- Decodes a packed unum4 word into a signed exponent and an aligned two's-complement mantissa with guard bits.
- Sits directly upstream of the pack/arithmetic datapath: its exp/mant outputs use the exact widths and format the pack stage consumes.
- Fixed-latency 3-stage pipeline with start/done strobes; accepts one word per cycle with no back-pressure.
- Also flags zero and special (exponent-size all-ones) encodings.

---
 rtl/unum4_unpack.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/unum4_unpack.sv
// unum4_unpack: three-stage pipeline that unpacks a unum4 word into a signed
// exponent and a guard-extended two's-complement mantissa for the pack stage.
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset
//   start   - in is valid this cycle
//   in      - packed unum4 word (exponent-size field in the LSBs)
//   done    - exp/mant/zero/special valid this cycle (3 edges after start)
//   exp     - decoded two's-complement exponent
//   mant    - {m, EXTRA zero guard bits}
//   zero    - word encodes zero
//   special - exponent-size field is all-ones
module unum4_unpack #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAN_MAX_W = 29,
    parameter int unsigned EXP_SZ_W  = 4,
    parameter int unsigned EXP_MAX_W = 16,
    parameter int unsigned EXTRA     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_W-1:0]             in,
    output logic                          done,
    output logic [EXP_MAX_W-1:0]          exp,
    output logic [MAN_MAX_W+EXTRA-1:0]    mant,
    output logic                          zero,
    output logic                          special
);

    localparam int unsigned FIELD_W = DATA_W - EXP_SZ_W;
    localparam int unsigned LOW_W   = MAN_MAX_W - 1;
    localparam int unsigned MANT_W  = MAN_MAX_W + EXTRA;
    localparam int unsigned SHAMT_W = $clog2(DATA_W) + 1;

    // Stage 1: captured input word and its valid bit
    logic              s1_valid;
    logic [DATA_W-1:0] s1_word;

    // Stage 2: extracted fields
    logic                 s2_valid;
    logic [MAN_MAX_W-1:0] s2_m;
    logic [EXP_MAX_W-1:0] s2_raw;
    logic                 s2_zero;
    logic                 s2_special;

    // Stage-2 combinational field extraction
    logic [EXP_SZ_W-1:0]  es;
    logic [FIELD_W-1:0]   field;
    logic [LOW_W-1:0]     m_low;
    logic [SHAMT_W-1:0]   shamt;
    logic [EXP_MAX_W-1:0] raw_u;
    logic [EXP_MAX_W-1:0] ext_mask;
    logic                 raw_sign;
    logic [EXP_MAX_W-1:0] raw;
    logic                 top;
    logic                 is_zero;
    logic                 is_special;

    // Stage-3 combinational correction
    logic [EXP_MAX_W-1:0] exp_n;
    logic [MANT_W-1:0]    mant_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= start;
            s1_word  <= in;
        end
    end

    // Field extraction: shifting the whole field left by es drops the
    // exponent bits off the top and zero-fills m[es-1:0]; shifting the word
    // right by DATA_W-es leaves just the exponent bits (0 when es==0).
    always_comb begin
        es         = s1_word[EXP_SZ_W-1:0];
        field      = s1_word[DATA_W-1:EXP_SZ_W];
        m_low      = LOW_W'(field << es);
        shamt      = SHAMT_W'(DATA_W) - SHAMT_W'(es);
        raw_u      = EXP_MAX_W'(s1_word >> shamt);
        ext_mask   = {EXP_MAX_W{1'b1}} << es;
        raw_sign   = 1'b0;
        if (es != '0) begin
            raw_sign = raw_u[es - 1'b1];
        end
        raw        = raw_sign ? (raw_u | ext_mask) : raw_u;
        is_special = &es;
        is_zero    = (s1_word == '0);
        top        = 1'b0;
        if (field == '0) begin
            top = 1'b0;
        end else if (is_special) begin
            top = m_low[LOW_W-1];
        end else begin
            top = ~m_low[LOW_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid   <= 1'b0;
            s2_m       <= '0;
            s2_raw     <= '0;
            s2_zero    <= 1'b0;
            s2_special <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_m       <= {top, m_low};
            s2_raw     <= raw;
            s2_zero    <= is_zero;
            s2_special <= is_special;
        end
    end

    // Negative exponents are bumped by 1 for a normalized 01/10 mantissa and
    // by 2 when the top two mantissa bits are equal.
    always_comb begin
        exp_n  = s2_raw;
        mant_n = {s2_m, EXTRA'(0)};
        if (s2_raw[EXP_MAX_W-1]) begin
            if (s2_m[MAN_MAX_W-1] != s2_m[MAN_MAX_W-2]) begin
                exp_n = s2_raw + EXP_MAX_W'(1);
            end else begin
                exp_n = s2_raw + EXP_MAX_W'(2);
            end
        end
        if (s2_zero) begin
            exp_n  = '0;
            mant_n = '0;
        end
    end

    // Output register: results load only with a valid word, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done    <= 1'b0;
            exp     <= '0;
            mant    <= '0;
            zero    <= 1'b0;
            special <= 1'b0;
        end else begin
            done <= s2_valid;
            if (s2_valid) begin
                exp     <= exp_n;
                mant    <= mant_n;
                zero    <= s2_zero;
                special <= s2_special;
            end
        end
    end

endmodule
